// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron datapath schedulers.
// Holds the scheduler state encoding, default sizing constants and the source slot map.
package snn_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    FIRE  = 1'b1
  } sched_state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_THRESHOLD  = 64;
  localparam int DEF_NUM_SRC    = 4;
  localparam int DEF_NUM_NEURON = 3;

  // Requester slots on the shared adder: three PE partial-sum ports, then membrane-in.
  localparam int SRC_PE0 = 0;
  localparam int SRC_PE1 = 1;
  localparam int SRC_PE2 = 2;
  localparam int SRC_MEM = 3;

endpackage

// File: rtl/membrane_update_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping around.
// Purely combinational so the grant can be used as a same-cycle ready.
module rr_arbiter
  import snn_pkg::*;
#(
  parameter int N     = DEF_NUM_SRC,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  int   w_idx;
  logic w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = int'(i_ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/membrane_update_sched.sv
// Membrane update scheduler: shares one adder among PE and membrane sources, then thresholds and emits pairs.
// Optional leak before the threshold compare is enabled by defining MEMBRANE_UPDATE_SCHED_LEAK_EN.
module membrane_update_sched
  import snn_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int NUM_NEURON = DEF_NUM_NEURON,
  parameter int THRESHOLD  = DEF_THRESHOLD,
  parameter int LEAK       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic                     mem_out_valid,
  output logic [WIDTH-1:0]         mem_out_data,
  output logic                     spike_out,
  input  logic                     mem_out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(NUM_NEURON + 1);
  localparam int IDX_W = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_NEURON);
  localparam logic [WIDTH-1:0] THR      = WIDTH'(THRESHOLD);
  localparam logic [WIDTH-1:0] LEAK_AMT = WIDTH'(LEAK);
`ifdef MEMBRANE_UPDATE_SCHED_LEAK_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif

  sched_state_t     r_state;
  logic [WIDTH-1:0] r_acc [NUM_NEURON];
  logic [CNT_W-1:0] r_cnt [NUM_SRC];
  logic [PTR_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_outIdx;
  logic             r_memValid;
  logic [WIDTH-1:0] r_memData;
  logic             r_spike;
  logic             r_done;

  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_grant;
  logic [PTR_W-1:0]   w_grantIdx;
  logic [WIDTH-1:0]   w_data;
  logic               w_xfer;
  logic               w_lastXfer;
  logic               w_anyCnt;
  logic [WIDTH-1:0]   w_raw;
  logic [WIDTH-1:0]   w_leaked;
  logic               w_fire;
  logic [WIDTH-1:0]   w_resid;

  // A source competes only while accumulating and until it has delivered one word per neuron.
  always_comb begin
    w_req      = '0;
    w_grantIdx = '0;
    w_data     = '0;
    w_anyCnt   = 1'b0;
    w_lastXfer = |w_grant;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_req[k] = src_valid[k] && (r_cnt[k] < CNT_FULL) && (r_state == ACCUM);
      if (w_grant[k]) begin
        w_grantIdx = PTR_W'(k);
        w_data     = src_data[k*WIDTH +: WIDTH];
      end
      if (r_cnt[k] != '0) w_anyCnt = 1'b1;
      w_lastXfer = w_lastXfer &&
                   (w_grant[k] ? (r_cnt[k] == CNT_FULL - 1'b1) : (r_cnt[k] == CNT_FULL));
    end
  end

  rr_arbiter #(
    .N     (NUM_SRC),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  assign w_xfer = |w_grant;

  // Leak (when built in) is applied before the compare; the compare is unsigned on the wrapped sum.
  always_comb begin
    w_raw = r_acc[r_outIdx];
    if (LEAK_ON) w_leaked = (w_raw > LEAK_AMT) ? w_raw - LEAK_AMT : '0;
    else         w_leaked = w_raw;
    w_fire  = (w_leaked >= THR);
    w_resid = w_fire ? w_leaked - THR : w_leaked;
  end

  always_ff @(posedge clk) begin
    r_done <= 1'b0;
    if (rst) begin
      r_state    <= ACCUM;
      r_ptr      <= '0;
      r_outIdx   <= '0;
      r_memValid <= 1'b0;
      r_memData  <= '0;
      r_spike    <= 1'b0;
      for (int n = 0; n < NUM_NEURON; n++) r_acc[n] <= '0;
      for (int k = 0; k < NUM_SRC; k++) r_cnt[k] <= '0;
    end else begin
      unique case (r_state)
        ACCUM: begin
          if (w_xfer) begin
            r_acc[r_cnt[w_grantIdx]] <= r_acc[r_cnt[w_grantIdx]] + w_data;
            r_cnt[w_grantIdx]        <= r_cnt[w_grantIdx] + 1'b1;
            r_ptr <= (w_grantIdx == PTR_W'(NUM_SRC - 1)) ? '0 : w_grantIdx + 1'b1;
            if (w_lastXfer) begin
              r_state  <= FIRE;
              r_outIdx <= '0;
            end
          end
        end
        FIRE: begin
          // Load a pair only when the slot is empty, which leaves a bubble after each handshake.
          if (!r_memValid) begin
            r_memValid <= 1'b1;
            r_memData  <= w_resid;
            r_spike    <= w_fire;
          end else if (mem_out_ready) begin
            r_memValid <= 1'b0;
            if (r_outIdx == IDX_W'(NUM_NEURON - 1)) begin
              r_state <= ACCUM;
              r_done  <= 1'b1;
              r_ptr   <= '0;
              for (int n = 0; n < NUM_NEURON; n++) r_acc[n] <= '0;
              for (int k = 0; k < NUM_SRC; k++) r_cnt[k] <= '0;
            end else begin
              r_outIdx <= r_outIdx + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign src_ready     = w_grant;
  assign mem_out_valid = r_memValid;
  assign mem_out_data  = r_memData;
  assign spike_out     = r_spike;
  assign done          = r_done;
  assign busy          = (r_state == FIRE) || w_anyCnt;

endmodule
